// File: rtl/dmem_access_unit.sv
// dmem_access_unit: RV32I load/store unit in front of a single-port,
// read-first, 1-cycle-latency data memory. Requests are range and size
// checked, split into one or two row accesses, and answered with a single
// resp_valid pulse carrying extended load data or a fault flag.
// Optional feature: define DMEM_MISALIGNED_EN to execute misaligned halfword
// and word accesses (including row-crossing ones); without it they fault.
module dmem_access_unit #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_5000,
    parameter logic [31:0] DMEM_LIMIT = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_A0   = 3'd1;
    localparam logic [2:0] S_A1   = 3'd2;
    localparam logic [2:0] S_A2   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        split_q, split_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] row0_data_q, row0_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;

    logic [2:0]  req_size_s;
    logic [32:0] last_addr_s;
    logic        req_split_s;
    logic        bad_code_s;
    logic        out_of_range_s;
    logic        misaligned_s;
    logic        req_fault_s;

    // Access size in bytes from the low two funct3 bits (B/H/W).
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Unshifted byte-enable mask for an access size.
    function automatic logic [3:0] byte_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   byte_mask = 4'b0001;
            2'b01:   byte_mask = 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    // Align the two-row window to the access offset, then size and extend.
    function automatic logic [31:0] load_extend(input logic [63:0] rows,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] s;
        s = 32'(rows >> {off, 3'b000});
        case (f3)
            3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
            3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
            3'b100:  load_extend = {24'd0, s[7:0]};
            3'b101:  load_extend = {16'd0, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    // Classify the incoming request: size, row crossing and every fault cause.
    always_comb begin
        req_size_s  = size_bytes(req_funct3[1:0]);
        last_addr_s = {1'b0, req_addr} + {30'd0, req_size_s} - 33'd1;
        req_split_s = ({1'b0, req_addr[1:0]} + req_size_s) > 3'd4;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: bad_code_s = 1'b0;
            3'b100, 3'b101:         bad_code_s = req_we;
            default:                bad_code_s = 1'b1;
        endcase
        out_of_range_s = (req_addr < DMEM_BASE) || (last_addr_s >= {1'b0, DMEM_LIMIT});
`ifdef DMEM_MISALIGNED_EN
        misaligned_s = 1'b0;
`else
        misaligned_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
        req_fault_s = bad_code_s || out_of_range_s || misaligned_s;
    end

    // Sequencer: next state, memory bus values and the response for next cycle.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        split_d      = split_q;
        wdata_d      = wdata_q;
        row0_data_d  = row0_data_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 4'b0000;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_fault_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d     = S_A0;
                        is_store_d  = req_we;
                        funct3_d    = req_funct3;
                        off_d       = req_addr[1:0];
                        split_d     = req_split_s;
                        wdata_d     = req_wdata;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                        mem_we_d    = req_we ? (byte_mask(req_funct3[1:0]) << req_addr[1:0]) : 4'b0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_A0: begin
                state_d = S_A1;
                // Row1 goes on the bus now so its data returns while A1 collects row0.
                if (split_q) begin
                    mem_addr_d  = mem_addr_q + 32'd4;
                    mem_wdata_d = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                    mem_we_d    = is_store_q ? (byte_mask(funct3_q[1:0]) >> (3'd4 - {1'b0, off_q})) : 4'b0000;
                end else begin
                    mem_addr_d = mem_addr_q;
                end
            end
            S_A1: begin
                row0_data_d = mem_rdata;
                if (split_q) begin
                    state_d = S_A2;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = is_store_q ? 32'd0 : load_extend({32'd0, mem_rdata}, off_q, funct3_q);
                end
            end
            S_A2: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = is_store_q ? 32'd0 : load_extend({mem_rdata, row0_data_q}, off_q, funct3_q);
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            split_q      <= 1'b0;
            wdata_q      <= 32'd0;
            row0_data_q  <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_we_q     <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            split_q      <= split_d;
            wdata_q      <= wdata_d;
            row0_data_q  <= row0_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: byte-level reference memory,
// per-cycle compare of DUT outputs against the expected transaction schedule,
// directed cases with literal expectations, then randomized traffic.
module tb_dmem_access_unit;

    localparam logic [31:0] BASE   = 32'h0000_5000;
    localparam logic [31:0] LIMIT  = 32'h0000_8000;
    localparam int          NWORDS = 3072;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    dmem_access_unit #(.DMEM_BASE(BASE), .DMEM_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory the DUT talks to (word array) and the reference byte memory.
    logic [31:0] sram [0:NWORDS-1];
    logic [7:0]  ref_mem [0:4*NWORDS-1];
    logic        init_en, poke_en;
    int          poke_idx;
    logic [31:0] poke_data;
    wire         sram_hit = (mem_addr >= BASE) && (mem_addr < LIMIT);
    wire [31:0]  sram_idx = (mem_addr - BASE) >> 2;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    endfunction

    // Read-first single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < NWORDS; i++) sram[i] <= init_word(i);
        end else if (poke_en) begin
            sram[poke_idx] <= poke_data;
        end else if (sram_hit) begin
            for (int j = 0; j < 4; j++)
                if (mem_we[j]) sram[sram_idx][8*j +: 8] <= mem_wdata[8*j +: 8];
        end
        mem_rdata <= sram_hit ? sram[sram_idx] : 32'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected schedule of the current transaction (k = acceptance edge).
    logic        txn_active, chk_en;
    int          exp_k, exp_resp_cyc;
    logic        exp_fault, exp_split, exp_store;
    logic [31:0] exp_rdata, exp_row0, exp_wd0, exp_wd1;
    logic [3:0]  exp_we0, exp_we1;
    int          last_resp_cyc;
    logic [31:0] last_rdata;
    logic        last_fault;

    function automatic logic [31:0] lane_bits(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    // Byte-level reference: legality, latency, lanes and load value.
    task automatic model_load(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int k);
        int size;
        logic bad;
        logic [31:0] val;
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        bad = 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
        if (we && (f3 == 3'b100 || f3 == 3'b101)) bad = 1'b1;
        if (addr < BASE) bad = 1'b1;
        if (longint'(addr) + size - 1 >= longint'(LIMIT)) bad = 1'b1;
`ifndef DMEM_MISALIGNED_EN
        if (size > 1 && (int'(addr[1:0]) % size) != 0) bad = 1'b1;
`endif
        exp_fault = bad;
        exp_store = we;
        exp_k     = k;
        exp_row0  = {addr[31:2], 2'b00};
        exp_split = !bad && (int'(addr[1:0]) + size > 4);
        exp_resp_cyc = bad ? k : (exp_split ? k + 3 : k + 2);
        exp_we0 = 4'd0; exp_we1 = 4'd0; exp_wd0 = 32'd0; exp_wd1 = 32'd0;
        val = 32'd0;
        if (!bad) begin
            for (int i = 0; i < size; i++) begin
                logic [31:0] a;
                int lane;
                a = addr + 32'(i);
                lane = int'(a[1:0]);
                if (we) begin
                    if (a[31:2] == addr[31:2]) begin
                        exp_we0[lane] = 1'b1;
                        exp_wd0[8*lane +: 8] = wd[8*i +: 8];
                    end else begin
                        exp_we1[lane] = 1'b1;
                        exp_wd1[8*lane +: 8] = wd[8*i +: 8];
                    end
                    ref_mem[int'(a - BASE)] = wd[8*i +: 8];
                end else begin
                    val[8*i +: 8] = ref_mem[int'(a - BASE)];
                end
            end
            if (!we && !f3[2] && size < 4 && val[8*size-1])
                val = val | ~((32'd1 << (8*size)) - 32'd1);
        end
        exp_rdata = (bad || we) ? 32'd0 : val;
        txn_active = 1'b1;
    endtask

    // Per-cycle compare of every DUT output against the expected schedule.
    always @(negedge clk) begin : compare
        logic       resp_now, busy;
        logic [3:0] we_exp;
        if (chk_en) begin
            resp_now = txn_active && (cyc == exp_resp_cyc);
            busy     = txn_active && (cyc >= exp_k) && (cyc <= exp_resp_cyc);
            check("resp_valid", {31'd0, resp_valid}, {31'd0, resp_now});
            check("resp_rdata", resp_rdata, resp_now ? exp_rdata : 32'd0);
            check("resp_fault", {31'd0, resp_fault}, {31'd0, resp_now && exp_fault});
            check("req_ready", {31'd0, req_ready}, {31'd0, !busy});
            we_exp = 4'd0;
            if (txn_active && !exp_fault && exp_store && cyc == exp_k) we_exp = exp_we0;
            if (txn_active && !exp_fault && exp_store && exp_split && cyc == exp_k + 1) we_exp = exp_we1;
            check("mem_we", {28'd0, mem_we}, {28'd0, we_exp});
            if (txn_active && !exp_fault && cyc == exp_k) begin
                check("mem_addr_row0", mem_addr, exp_row0);
                if (exp_store) check("mem_wdata_row0", mem_wdata & lane_bits(exp_we0), exp_wd0);
            end
            if (txn_active && exp_split && cyc == exp_k + 1) begin
                check("mem_addr_row1", mem_addr, exp_row0 + 32'd4);
                if (exp_store) check("mem_wdata_row1", mem_wdata & lane_bits(exp_we1), exp_wd1);
            end
            if (resp_valid === 1'b1) begin
                last_resp_cyc = cyc;
                last_rdata    = resp_rdata;
                last_fault    = resp_fault;
            end
        end
    end

    // Present one request and wait for its acceptance edge.
    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", {31'd0, req_ready}, 32'd1);
        last_resp_cyc = -1;
        model_load(we, f3, addr, wd, cyc + 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Run out the transaction while throwing ignored junk at the request port.
    task automatic finish_txn();
        while (cyc <= exp_resp_cyc) begin
            req_valid  = 1'($urandom);
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        poke_idx = int'((addr - BASE) >> 2); poke_data = data; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
        for (int j = 0; j < 4; j++) ref_mem[int'(addr - BASE) + j] = data[8*j +: 8];
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        accept(we, f3, addr, wd);
        finish_txn();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  codes [5];
        logic [31:0] a37;
        logic [2:0]  f3;
        logic [31:0] addr;
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; init_en = 1'b1; poke_en = 1'b0;
        poke_idx = 0; poke_data = 32'd0; chk_en = 1'b0; txn_active = 1'b0;
        last_resp_cyc = -1; last_rdata = 32'd0; last_fault = 1'b0;
        for (int i = 0; i < NWORDS; i++)
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = init_word(i) >> (8*j);
        repeat (3) @(posedge clk);
        #1;
        init_en = 1'b0; rst = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        chk_en = 1'b1;

        // SW aligned word
        accept(1'b1, 3'b010, 32'h5000, 32'hDEAD_BEEF);
        check("sw_c1_addr", mem_addr, 32'h0000_5000);
        check("sw_c1_we", {28'd0, mem_we}, 32'h0000_000F);
        check("sw_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        finish_txn();
        check("sw_latency", 32'(last_resp_cyc - exp_k), 32'd2);
        check("sw_fault", {31'd0, last_fault}, 32'd0);

        // Load sign/zero extension
        poke(32'h5004, 32'h80FF_7F01);
        run(1'b0, 3'b000, 32'h5006, 32'd0);
        check("lb_5006", last_rdata, 32'hFFFF_FFFF);
        run(1'b0, 3'b100, 32'h5006, 32'd0);
        check("lbu_5006", last_rdata, 32'h0000_00FF);
        run(1'b0, 3'b001, 32'h5006, 32'd0);
        check("lh_5006", last_rdata, 32'hFFFF_80FF);

        // SB at lane 3
        accept(1'b1, 3'b000, 32'h5003, 32'h0000_00AB);
        check("sb_we", {28'd0, mem_we}, 32'h0000_0008);
        check("sb_wdata", mem_wdata, 32'hAB00_0000);
        finish_txn();

        // Row-crossing LW
        poke(32'h5000, 32'h4433_2211);
        poke(32'h5004, 32'h8877_6655);
        accept(1'b0, 3'b010, 32'h5002, 32'd0);
`ifdef DMEM_MISALIGNED_EN
        check("lw_split_row0", mem_addr, 32'h0000_5000);
        @(posedge clk); #1;
        check("lw_split_row1", mem_addr, 32'h0000_5004);
        finish_txn();
        check("lw_split_latency", 32'(last_resp_cyc - exp_k), 32'd3);
        check("lw_split_data", last_rdata, 32'h6655_4433);
`else
        finish_txn();
        check("lw_mis_latency", 32'(last_resp_cyc - exp_k), 32'd0);
        check("lw_mis_fault", {31'd0, last_fault}, 32'd1);
`endif

        // Range and code boundaries
        run(1'b0, 3'b010, 32'h7FFC, 32'd0);
        check("lw_7ffc_fault", {31'd0, last_fault}, 32'd0);
        check("lw_7ffc_latency", 32'(last_resp_cyc - exp_k), 32'd2);
        run(1'b0, 3'b010, 32'h8000, 32'd0);
        check("lw_8000_fault", {31'd0, last_fault}, 32'd1);
        check("lw_8000_rdata", last_rdata, 32'd0);
        run(1'b0, 3'b010, 32'h4FFC, 32'd0);
        check("lw_4ffc_fault", {31'd0, last_fault}, 32'd1);
        run(1'b0, 3'b011, 32'h5000, 32'd0);
        check("f3_011_fault", {31'd0, last_fault}, 32'd1);
        check("f3_011_rdata", last_rdata, 32'd0);

        // Reset while in A1 of a store (row-crossing when misaligned support is on)
`ifdef DMEM_MISALIGNED_EN
        a37 = 32'h5FFE;
`else
        a37 = 32'h5FFC;
`endif
        accept(1'b1, 3'b010, a37, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        txn_active = 1'b0;
        rst = 1'b0;
        check("midrst_mem_we", {28'd0, mem_we}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_mem_addr", mem_addr, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        run(1'b0, 3'b000, a37, 32'd0);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            f3 = ($urandom_range(0, 15) == 0) ? 3'($urandom) : codes[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0)
                addr = (($urandom_range(0, 1) == 1) ? LIMIT : BASE) - 32'd4 + 32'($urandom_range(0, 7));
            else
                addr = BASE + 32'($urandom_range(0, 32'h2FFF));
            run(1'($urandom), f3, addr, $urandom);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
